ula_sequencial: RTL and testbench

//  Parametrised successor of the 8-bit combinational ALU; compatible with its five opcodes when sinal_ula[3]=0.

---
 rtl/ula_pkg.sv | 33 +++
 rtl/ula_mult_iterativa.sv | 64 ++++++
 rtl/ula_sequencial.sv | 168 ++++++++++++++++
 tb/tb_ula_sequencial.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and flag-bit positions.
package ula_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_SLTS = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;

  typedef enum logic [1:0] {
    StOcioso    = 2'd0,
    StMult      = 2'd1,
    StResultado = 2'd2
  } estado_t;

  localparam int unsigned FLAG_ZERO     = 0;
  localparam int unsigned FLAG_CARRY    = 1;
  localparam int unsigned FLAG_OVERFLOW = 2;
  localparam int unsigned FLAG_NEGATIVO = 3;
  localparam int unsigned FLAG_ERRO     = 4;
  localparam int unsigned NUM_FLAGS     = 5;

  // After reset the (zero) result reads as zero.
  localparam logic [NUM_FLAGS-1:0] FLAGS_RESET = 5'b00001;

endpackage

// File: rtl/ula_mult_iterativa.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, LARGURA cycles.
module ula_mult_iterativa #(
  parameter int unsigned LARGURA = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [LARGURA-1:0]     multiplicando,
  input  logic [LARGURA-1:0]     multiplicador,
  output logic                   busy,
  output logic                   done,
  output logic [2*LARGURA-1:0]   produto
);

  localparam int unsigned CW = $clog2(LARGURA + 1);

  logic [2*LARGURA-1:0] produto_q, produto_d;
  logic [LARGURA-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic [LARGURA:0]     soma;

  // Upper half accumulates; the multiplier sits in the lower half and shifts out LSB-first.
  always_comb begin
    soma      = {1'b0, produto_q[2*LARGURA-1:LARGURA]} +
                (produto_q[0] ? {1'b0, mcand_q} : '0);
    produto_d = produto_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    if (start) begin
      produto_d = {{LARGURA{1'b0}}, multiplicador};
      mcand_d   = multiplicando;
      cnt_d     = CW'(LARGURA);
      busy_d    = 1'b1;
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        produto_d = {soma, produto_q[LARGURA-1:1]};
        cnt_d     = cnt_q - 1'b1;
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      produto_q <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      produto_q <= produto_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == '0);
  assign produto = produto_q;

endmodule

// File: rtl/ula_sequencial.sv
// Sequential ALU with valid/ready handshakes, status flags and an iterative multiplier.
module ula_sequencial
  import ula_pkg::*;
#(
  parameter int unsigned LARGURA  = 8,
  parameter int unsigned DESLOC_W = $clog2(LARGURA)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               entrada_valida,
  output logic               entrada_pronta,
  input  logic [LARGURA-1:0] entrada1,
  input  logic [LARGURA-1:0] entrada2,
  input  logic [3:0]         sinal_ula,
  output logic               saida_valida,
  input  logic               saida_aceita,
  output logic [LARGURA-1:0] saida_ula,
  output logic [LARGURA-1:0] saida_alta,
  output logic               zero,
  output logic               carry,
  output logic               overflow,
  output logic               negativo,
  output logic               erro
);

  localparam int unsigned MSB = LARGURA - 1;

  estado_t                estado_q, estado_d;
  logic [LARGURA-1:0]     saida_ula_q, saida_ula_d;
  logic [LARGURA-1:0]     saida_alta_q, saida_alta_d;
  logic [NUM_FLAGS-1:0]   flags_q, flags_d;

  logic                   transf, e_mul, carrega_alu, carrega_mul, mult_start;
  logic                   mult_busy, mult_done;
  logic [2*LARGURA-1:0]   produto;

  logic [LARGURA-1:0]     res;
  logic [LARGURA:0]       soma, dif;
  logic [DESLOC_W-1:0]    desloc;
  logic                   carry_c, ovf_c, erro_c;

  ula_mult_iterativa #(
    .LARGURA(LARGURA)
  ) u_mult (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (mult_start),
    .multiplicando(entrada1),
    .multiplicador(entrada2),
    .busy         (mult_busy),
    .done         (mult_done),
    .produto      (produto)
  );

  // Single-cycle datapath; evaluated from the live inputs and captured on the transfer edge.
  always_comb begin
    res     = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    erro_c  = 1'b0;
    soma    = {1'b0, entrada1} + {1'b0, entrada2};
    dif     = {1'b0, entrada1} - {1'b0, entrada2};
    desloc  = entrada2[DESLOC_W-1:0];
    case (sinal_ula)
      OP_AND:  res = entrada1 & entrada2;
      OP_OR:   res = entrada1 | entrada2;
      OP_ADD: begin
        res     = soma[LARGURA-1:0];
        carry_c = soma[LARGURA];
        ovf_c   = (entrada1[MSB] == entrada2[MSB]) && (soma[MSB] != entrada1[MSB]);
      end
      OP_SUB: begin
        res     = dif[LARGURA-1:0];
        carry_c = dif[LARGURA];
        ovf_c   = (entrada1[MSB] != entrada2[MSB]) && (dif[MSB] != entrada1[MSB]);
      end
      OP_SLT:  res = {{(LARGURA-1){1'b0}}, (entrada1 < entrada2)};
      OP_SLTS: res = {{(LARGURA-1){1'b0}}, ($signed(entrada1) < $signed(entrada2))};
      OP_XOR:  res = entrada1 ^ entrada2;
      OP_NOR:  res = ~(entrada1 | entrada2);
      OP_SLL:  res = entrada1 << desloc;
      OP_SRL:  res = entrada1 >> desloc;
      OP_SRA:  res = $unsigned($signed(entrada1) >>> desloc);
      OP_MUL:  res = '0;
      default: erro_c = 1'b1;
    endcase
  end

  always_comb begin
    entrada_pronta = (estado_q == StOcioso) || ((estado_q == StResultado) && saida_aceita);
    transf         = entrada_valida && entrada_pronta;
    e_mul          = (sinal_ula == OP_MUL);
    estado_d       = estado_q;
    carrega_alu    = 1'b0;
    carrega_mul    = 1'b0;
    mult_start     = 1'b0;
    case (estado_q)
      StOcioso, StResultado: begin
        if ((estado_q == StResultado) && saida_aceita) estado_d = StOcioso;
        if (transf) begin
          if (e_mul) begin
            estado_d   = StMult;
            mult_start = 1'b1;
          end else begin
            estado_d    = StResultado;
            carrega_alu = 1'b1;
          end
        end
      end
      StMult: begin
        if (mult_done) begin
          estado_d    = StResultado;
          carrega_mul = 1'b1;
        end else if (!mult_busy) begin
          estado_d = StOcioso;  // multiplier lost its operation; never stall here
        end
      end
      default: estado_d = StOcioso;
    endcase
  end

  always_comb begin
    saida_ula_d  = saida_ula_q;
    saida_alta_d = saida_alta_q;
    flags_d      = flags_q;
    if (carrega_alu) begin
      saida_ula_d             = res;
      saida_alta_d            = '0;
      flags_d[FLAG_ZERO]      = (res == '0);
      flags_d[FLAG_CARRY]     = carry_c;
      flags_d[FLAG_OVERFLOW]  = ovf_c;
      flags_d[FLAG_NEGATIVO]  = res[MSB];
      flags_d[FLAG_ERRO]      = erro_c;
    end else if (carrega_mul) begin
      saida_ula_d             = produto[LARGURA-1:0];
      saida_alta_d            = produto[2*LARGURA-1:LARGURA];
      flags_d[FLAG_ZERO]      = (produto == '0);
      flags_d[FLAG_CARRY]     = 1'b0;
      flags_d[FLAG_OVERFLOW]  = 1'b0;
      flags_d[FLAG_NEGATIVO]  = produto[MSB];
      flags_d[FLAG_ERRO]      = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      estado_q     <= StOcioso;
      saida_ula_q  <= '0;
      saida_alta_q <= '0;
      flags_q      <= FLAGS_RESET;
    end else begin
      estado_q     <= estado_d;
      saida_ula_q  <= saida_ula_d;
      saida_alta_q <= saida_alta_d;
      flags_q      <= flags_d;
    end
  end

  assign saida_valida = (estado_q == StResultado);
  assign saida_ula    = saida_ula_q;
  assign saida_alta   = saida_alta_q;
  assign zero         = flags_q[FLAG_ZERO];
  assign carry        = flags_q[FLAG_CARRY];
  assign overflow     = flags_q[FLAG_OVERFLOW];
  assign negativo     = flags_q[FLAG_NEGATIVO];
  assign erro         = flags_q[FLAG_ERRO];

endmodule

// File: tb/tb_ula_sequencial.sv
// Self-checking bench for ula_sequencial: vector table plus handshake, latency and reset sequences.
module tb_ula_sequencial;
  import ula_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       entrada_valida = 1'b0;
  logic       entrada_pronta;
  logic [7:0] entrada1 = '0;
  logic [7:0] entrada2 = '0;
  logic [3:0] sinal_ula = '0;
  logic       saida_valida;
  logic       saida_aceita = 1'b0;
  logic [7:0] saida_ula, saida_alta;
  logic       zero, carry, overflow, negativo, erro;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  ula_sequencial #(.LARGURA(8)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .entrada_valida(entrada_valida),
    .entrada_pronta(entrada_pronta),
    .entrada1      (entrada1),
    .entrada2      (entrada2),
    .sinal_ula     (sinal_ula),
    .saida_valida  (saida_valida),
    .saida_aceita  (saida_aceita),
    .saida_ula     (saida_ula),
    .saida_alta    (saida_alta),
    .zero          (zero),
    .carry         (carry),
    .overflow      (overflow),
    .negativo      (negativo),
    .erro          (erro)
  );

  typedef struct {
    logic [7:0] ula, alta;
    logic       z, c, v, n, e;
  } esp_t;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a, b;
    esp_t       esp;
  } vec_t;

  esp_t sb[$];
  esp_t mon_e;

  task automatic chk(input string nome, input logic [15:0] atual, input logic [15:0] esperado);
    total++;
    if (atual !== esperado) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
    end
  endtask

  // Scoreboard: every accepted result is compared against the oldest pending expectation.
  always @(negedge clock) begin
    if (reset_n && saida_valida && saida_aceita) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got result %0h expected none", saida_ula);
      end else begin
        mon_e = sb.pop_front();
        chk("res_ula", 16'(saida_ula), 16'(mon_e.ula));
        chk("res_alta", 16'(saida_alta), 16'(mon_e.alta));
        chk("res_zero", 16'(zero), 16'(mon_e.z));
        chk("res_carry", 16'(carry), 16'(mon_e.c));
        chk("res_overflow", 16'(overflow), 16'(mon_e.v));
        chk("res_negativo", 16'(negativo), 16'(mon_e.n));
        chk("res_erro", 16'(erro), 16'(mon_e.e));
      end
    end
  end

  // Drives one operation and returns just after its transfer edge; entrada_valida stays high.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input esp_t e, input bit empurra, output int espera);
    entrada_valida = 1'b1;
    sinal_ula      = op;
    entrada1       = a;
    entrada2       = b;
    espera         = 0;
    while (1) begin
      @(negedge clock);
      if (entrada_pronta) break;
      espera++;
      if (espera > 40) begin
        total++;
        bad++;
        $display("FAIL issue_timeout: got pronta=0 for %0d cycles expected pronta=1", espera);
        return;
      end
    end
    @(posedge clock);
    #1;
    if (empurra) sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_vec(input vec_t v);
    int w;
    saida_aceita = 1'b1;
    issue(v.op, v.a, v.b, v.esp, 1'b1, w);
    entrada_valida = 1'b0;
    if (v.op != OP_MUL) chk("lat1_valid", 16'(saida_valida), 16'd1);
    drain();
  endtask

  vec_t vecs[17];

  initial begin
    int   w, n, pronta_bad;
    esp_t nada;
    nada = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    //          op       a      b       ula    alta   z     c     v     n     e
    vecs[0]  = '{OP_ADD,  8'hFF, 8'h01, '{8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[1]  = '{OP_SUB,  8'h80, 8'h01, '{8'h7F, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[2]  = '{OP_SLTS, 8'hFF, 8'h01, '{8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[3]  = '{OP_SLT,  8'hFF, 8'h01, '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[4]  = '{OP_SRA,  8'h90, 8'h0B, '{8'hF2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[5]  = '{4'b1100, 8'h55, 8'hAA, '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}};
    vecs[6]  = '{OP_AND,  8'hF0, 8'h3C, '{8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[7]  = '{OP_OR,   8'hF0, 8'h0C, '{8'hFC, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[8]  = '{OP_XOR,  8'hAA, 8'hFF, '{8'h55, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[9]  = '{OP_NOR,  8'h0F, 8'hF0, '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[10] = '{OP_SLL,  8'h81, 8'h09, '{8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[11] = '{OP_SRL,  8'h81, 8'h04, '{8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[12] = '{OP_SUB,  8'h01, 8'h02, '{8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[13] = '{OP_ADD,  8'h7F, 8'h01, '{8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}};
    vecs[14] = '{4'b1111, 8'h12, 8'h34, '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}};
    vecs[15] = '{OP_MUL,  8'h03, 8'h05, '{8'h0F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[16] = '{OP_SLTS, 8'h01, 8'hFF, '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}};

    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    chk("rst_valid", 16'(saida_valida), 16'd0);
    chk("rst_pronta", 16'(entrada_pronta), 16'd1);
    chk("rst_zero", 16'(zero), 16'd1);
    chk("rst_ula", 16'(saida_ula), 16'd0);
    chk("rst_alta", 16'(saida_alta), 16'd0);
    chk("rst_flags", 16'({carry, overflow, negativo, erro}), 16'd0);

    for (int i = 0; i < 17; i++) run_vec(vecs[i]);

    // MUL latency and pronta held low while iterating.
    saida_aceita = 1'b0;
    issue(OP_MUL, 8'hFF, 8'hFF, '{8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1, w);
    entrada_valida = 1'b0;
    n = 0;
    pronta_bad = 0;
    while (!saida_valida && n < 30) begin
      if (entrada_pronta) pronta_bad++;
      @(posedge clock);
      #1;
      n++;
    end
    chk("mul_latency", 16'(n), 16'd9);
    chk("mul_pronta_low", 16'(pronta_bad), 16'd0);
    saida_aceita = 1'b1;
    drain();

    // Result held while consumer stalls and inputs toggle.
    saida_aceita = 1'b0;
    issue(OP_ADD, 8'h10, 8'h20, '{8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1, w);
    for (int i = 0; i < 5; i++) begin
      sinal_ula = 4'($urandom);
      entrada1  = 8'($urandom);
      entrada2  = 8'($urandom);
      @(posedge clock);
      #1;
      chk("hold_ula", 16'(saida_ula), 16'h30);
      chk("hold_alta", 16'(saida_alta), 16'h00);
      chk("hold_valid", 16'(saida_valida), 16'd1);
    end
    saida_aceita = 1'b1;
    issue(OP_SUB, 8'h09, 8'h04, '{8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1, w);
    chk("same_cycle_accept", 16'(w), 16'd0);
    issue(OP_XOR, 8'h0F, 8'hFF, '{8'hF0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}, 1'b1, w);
    chk("b2b_xor", 16'(w), 16'd0);
    issue(OP_OR, 8'h01, 8'h02, '{8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1, w);
    chk("b2b_or", 16'(w), 16'd0);
    entrada_valida = 1'b0;
    drain();

    // Reset in the fourth MULT cycle discards the product.
    saida_aceita = 1'b0;
    issue(OP_MUL, 8'h07, 8'h06, nada, 1'b0, w);
    entrada_valida = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    chk("mrst_valid", 16'(saida_valida), 16'd0);
    chk("mrst_pronta", 16'(entrada_pronta), 16'd1);
    chk("mrst_zero", 16'(zero), 16'd1);
    chk("mrst_ula", 16'(saida_ula), 16'd0);
    chk("mrst_alta", 16'(saida_alta), 16'd0);
    run_vec('{OP_ADD, 8'h02, 8'h03, '{8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}});
    run_vec('{OP_MUL, 8'h0C, 8'h0B, '{8'h84, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}});

    repeat (2) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
